// File: rtl/maze_pkg.sv
// Shared constants and types for the maze tile RAM scanner.
package maze_pkg;

   localparam int SIZE_X     = 40;
   localparam int SIZE_Y     = 20;
   localparam int IDX_W      = 6;
   localparam int TILE_W     = 4;
   localparam int STARVE_MAX = 8;
   localparam int STARVE_W   = 4;
   localparam int CNT_W      = 10;

   typedef logic [TILE_W-1:0] tile_t;

   localparam tile_t TILE_COIN = 4'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } scan_state_t;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_GL   = 2'd1,
      TAG_SCAN = 2'd2
   } rd_tag_t;

endpackage

// File: rtl/raster_index_gen.sv
// Raster x/y index over the maze grid. Wraps to (0,0) after the last tile,
// so an out-of-range address is never produced.
module raster_index_gen
   import maze_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             advance,
   input  logic             clear,
   output logic [IDX_W-1:0] x,
   output logic [IDX_W-1:0] y,
   output logic             last
);

   localparam logic [IDX_W-1:0] X_MAX = IDX_W'(SIZE_X - 1);
   localparam logic [IDX_W-1:0] Y_MAX = IDX_W'(SIZE_Y - 1);

   assign last = (x == X_MAX) && (y == Y_MAX);

   // Step x each slot, carry into y at end of row, wrap to origin after the last tile.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         x <= '0;
         y <= '0;
      end else if (clear) begin
         x <= '0;
         y <= '0;
      end else if (advance) begin
         if (x == X_MAX) begin
            x <= '0;
            y <= (y == Y_MAX) ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

endmodule

// File: rtl/coin_scan_arbiter.sv
// Shares the single-port maze tile RAM between game logic (priority) and a
// raster scanner that counts coin tiles once per started round.
//
// state | meaning
// IDLE  | waiting for start; game logic served
// SCAN  | scanner uses every slot game logic leaves free (forced after STARVE_MAX grants)
// DRAIN | last scanner read returns and is counted
// DONE  | publish coin_count/level_clear, pulse round_done, clear accumulator
module coin_scan_arbiter
   import maze_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   input  logic              gl_req,
   input  logic              gl_we,
   input  logic [IDX_W-1:0]  gl_x,
   input  logic [IDX_W-1:0]  gl_y,
   input  logic [TILE_W-1:0] gl_wdata,
   output logic              gl_grant,
   output logic              gl_rvalid,
   output logic [IDX_W-1:0]  ram_x,
   output logic [IDX_W-1:0]  ram_y,
   output logic              ram_we,
   output logic [TILE_W-1:0] ram_wdata,
   input  logic [TILE_W-1:0] ram_rdata,
   output logic              busy,
   output logic              round_done,
   output logic [CNT_W-1:0]  coin_count,
   output logic              level_clear
);

   scan_state_t         state, state_nxt;
   rd_tag_t             tag, tag_nxt;
   logic [STARVE_W-1:0] starve;
   logic [CNT_W-1:0]    accum;
   logic                scan_slot;
   logic [IDX_W-1:0]    scan_x, scan_y;
   logic                scan_last;

   raster_index_gen u_index (
      .Clk     (Clk),
      .Reset   (Reset),
      .advance (scan_slot),
      .clear   (state == IDLE),
      .x       (scan_x),
      .y       (scan_y),
      .last    (scan_last)
   );

   // Per-cycle arbitration and RAM port mux; the scanner only gets slots game logic leaves.
   always_comb begin
      gl_grant  = gl_req && !((state == SCAN) && (starve == STARVE_W'(STARVE_MAX)));
      scan_slot = (state == SCAN) && !gl_grant;
      ram_x     = scan_x;
      ram_y     = scan_y;
      ram_we    = 1'b0;
      ram_wdata = '0;
      tag_nxt   = TAG_NONE;
      if (gl_grant) begin
         ram_x     = gl_x;
         ram_y     = gl_y;
         ram_we    = gl_we;
         ram_wdata = gl_wdata;
         tag_nxt   = gl_we ? TAG_NONE : TAG_GL;
      end else if (scan_slot) begin
         tag_nxt   = TAG_SCAN;
      end
   end

   // Round sequencing; start outside IDLE is dropped.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = SCAN;
         SCAN:    if (scan_slot && scan_last) state_nxt = DRAIN;
         DRAIN:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Consecutive game-logic grants while scanning; any scanner slot resets it.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)                     starve <= '0;
      else if (state != SCAN)        starve <= '0;
      else if (gl_grant)             starve <= starve + 1'b1;
      else                           starve <= '0;
   end

   // Remember who owns next cycle's read data.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) tag <= TAG_NONE;
      else       tag <= tag_nxt;
   end

   // Count coins as scanner reads return; publish and restart the count in DONE.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         accum       <= '0;
         coin_count  <= '0;
         level_clear <= 1'b0;
      end else if (state == DONE) begin
         coin_count  <= accum;
         level_clear <= (accum == '0);
         accum       <= '0;
      end else if ((tag == TAG_SCAN) && (ram_rdata == TILE_COIN)) begin
         accum       <= accum + 1'b1;
      end
   end

   assign gl_rvalid  = (tag == TAG_GL);
   assign busy       = (state != IDLE);
   assign round_done = (state == DONE);

endmodule

// File: tb/tb_coin_scan_arbiter.sv
// Directed bench for coin_scan_arbiter with a behavioural 1-cycle-latency tile RAM.
module tb_coin_scan_arbiter;
   import maze_pkg::*;

   logic              Clk = 1'b0;
   logic              Reset;
   logic              start, gl_req, gl_we;
   logic [IDX_W-1:0]  gl_x, gl_y, ram_x, ram_y;
   logic [TILE_W-1:0] gl_wdata, ram_wdata, ram_rdata;
   logic              gl_grant, gl_rvalid, ram_we, busy, round_done, level_clear;
   logic [CNT_W-1:0]  coin_count;

   int checks = 0;
   int fails  = 0;

   always #5 Clk = ~Clk;

   coin_scan_arbiter dut (
      .Clk(Clk), .Reset(Reset), .start(start),
      .gl_req(gl_req), .gl_we(gl_we), .gl_x(gl_x), .gl_y(gl_y), .gl_wdata(gl_wdata),
      .gl_grant(gl_grant), .gl_rvalid(gl_rvalid),
      .ram_x(ram_x), .ram_y(ram_y), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .busy(busy), .round_done(round_done), .coin_count(coin_count), .level_clear(level_clear)
   );

   // Tile RAM model, flat index y*SIZE_X+x, bulk image load for preloading.
   logic [TILE_W-1:0] mem [0:SIZE_X*SIZE_Y-1];
   logic [TILE_W-1:0] img [0:SIZE_X*SIZE_Y-1];
   logic              load = 1'b0;
   int                addr;
   assign addr = int'(ram_y) * SIZE_X + int'(ram_x);

   always @(posedge Clk) begin
      if (load) begin
         for (int i = 0; i < SIZE_X*SIZE_Y; i++) mem[i] <= img[i];
      end else if (ram_we && addr < SIZE_X*SIZE_Y) begin
         mem[addr] <= ram_wdata;
      end
      if (addr < SIZE_X*SIZE_Y) ram_rdata <= mem[addr];
      else                      ram_rdata <= '0;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // n coins at distinct positions (37 is coprime to 800), plus an optional extra tile.
   task automatic load_img(input int n, input int extra);
      for (int i = 0; i < SIZE_X*SIZE_Y; i++) img[i] = '0;
      for (int i = 0; i < n; i++) img[(i*37) % (SIZE_X*SIZE_Y)] = TILE_COIN;
      if (extra >= 0) img[extra] = TILE_COIN;
      tick();
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   function automatic logic [31:0] out_vec();
      return {busy, round_done, level_clear, gl_rvalid, gl_grant, ram_we,
              coin_count, ram_x, ram_y, ram_wdata};
   endfunction

   // act: 0 none, 1 extra start at SCAN cycle 100, 2 GL read at 50 and write at 300,
   //      3 reset at SCAN cycle 400 (exp_lat < 0 means no round_done expected).
   task automatic run_round(input string nm, input int exp_cnt, input bit exp_clr,
                            input int exp_lat, input bit hold, input int act);
      int lat, pulses, bad, bound;
      lat = -1; pulses = 0; bad = 0;
      bound = (exp_lat < 0) ? 1200 : exp_lat + 300;
      gl_req = hold; gl_we = 1'b0; gl_x = '0; gl_y = '0; gl_wdata = '0;
      tick();
      start = 1'b1;
      @(negedge Clk);
      tick();
      start = 1'b0;
      for (int k = 1; k <= bound; k++) begin
         if (act == 1) start = (k == 100);
         if (act == 2) begin
            if (k == 50)  begin gl_req = 1'b1; gl_we = 1'b0; gl_x = 6'd5; gl_y = 6'd3; end
            if (k == 51)  gl_req = 1'b0;
            if (k == 300) begin gl_req = 1'b1; gl_we = 1'b1; gl_x = 6'd1; gl_y = 6'd0; gl_wdata = TILE_COIN; end
            if (k == 301) begin gl_req = 1'b0; gl_we = 1'b0; end
         end
         if (act == 3) begin
            if (k == 400) Reset = 1'b1;
            if (k == 402) Reset = 1'b0;
         end
         @(negedge Clk);
         if (act == 2 && k == 50)  chk({nm, "_gl_read_grant"}, {gl_grant, ram_x, ram_y}, {1'b1, 6'd5, 6'd3});
         if (act == 2 && k == 51)  chk({nm, "_gl_rvalid_data"}, {gl_rvalid, ram_rdata}, {1'b1, TILE_COIN});
         if (act == 2 && k == 301) chk({nm, "_no_rvalid_after_write"}, gl_rvalid, 0);
         if (act == 3 && k == 400) chk({nm, "_outputs_in_reset"}, out_vec(), 0);
         if (round_done) begin
            pulses++;
            if (lat < 0) lat = k;
         end
         if (hold && k <= 7200 && gl_grant !== ((k % 9) != 0)) bad++;
         tick();
      end
      gl_req = 1'b0;
      @(negedge Clk);
      chk({nm, "_round_done_pulses"}, pulses, (exp_lat < 0) ? 0 : 1);
      if (hold) chk({nm, "_grant_pattern_errors"}, bad, 0);
      if (exp_lat >= 0) begin
         chk({nm, "_latency"}, lat, exp_lat);
         chk({nm, "_coin_count"}, coin_count, exp_cnt);
         chk({nm, "_level_clear"}, level_clear, exp_clr);
      end else begin
         chk({nm, "_idle_after_abort"}, {busy, coin_count}, 0);
      end
   endtask

   typedef struct {
      string name;
      int    ncoin;
      int    extra;
      int    exp_cnt;
      bit    exp_clr;
      int    exp_lat;
      bit    hold;
      int    act;
   } vec_t;

   vec_t vecs [7];

   initial begin
      vecs[0] = '{"three_coins", 3,   -1,  3,   1'b0, 802,  1'b0, 0};
      vecs[1] = '{"empty",       0,   -1,  0,   1'b1, 802,  1'b0, 0};
      vecs[2] = '{"one_coin",    1,   -1,  1,   1'b0, 802,  1'b0, 0};
      vecs[3] = '{"all_coins",   800, -1,  800, 1'b0, 802,  1'b0, 0};
      vecs[4] = '{"starved",     5,   -1,  5,   1'b0, 7202, 1'b1, 0};
      vecs[5] = '{"start_mid",   7,   -1,  7,   1'b0, 802,  1'b0, 1};
      vecs[6] = '{"gl_rw",       4,   125, 5,   1'b0, 804,  1'b0, 2};

      Reset = 1'b1; start = 1'b0; gl_req = 1'b0; gl_we = 1'b0;
      gl_x = '0; gl_y = '0; gl_wdata = '0;
      #12;
      chk("reset_outputs", out_vec(), 0);
      tick();
      Reset = 1'b0;

      for (int i = 0; i < 7; i++) begin
         load_img(vecs[i].ncoin, vecs[i].extra);
         run_round(vecs[i].name, vecs[i].exp_cnt, vecs[i].exp_clr,
                   vecs[i].exp_lat, vecs[i].hold, vecs[i].act);
      end

      // Empty level, then a coin written by game logic at the last tile and rescanned.
      load_img(0, -1);
      run_round("empty_again", 0, 1'b1, 802, 1'b0, 0);
      tick();
      gl_req = 1'b1; gl_we = 1'b1; gl_x = 6'd39; gl_y = 6'd19; gl_wdata = TILE_COIN;
      @(negedge Clk);
      chk("idle_gl_write_grant", {gl_grant, ram_we}, 2'b11);
      tick();
      gl_req = 1'b0; gl_we = 1'b0;
      run_round("rescan", 1, 1'b0, 802, 1'b0, 0);

      // Reset mid-round abandons it; a fresh round then counts correctly.
      load_img(6, -1);
      run_round("aborted", 0, 1'b0, -1, 1'b0, 3);
      run_round("after_reset", 6, 1'b0, 802, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
